// File: rtl/card_shoe_dealer.sv
// 52-card shoe: identity fill, LFSR-driven Fisher-Yates shuffle, one card per accepted draw.
// Each dealt card carries its index plus rank/suit/blackjack value decode.
module card_shoe_dealer #(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter bit          SHUFFLE_EN     = 1'b1,
    parameter bit          AUTO_RESHUFFLE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw_req,
    input  logic       shuffle_req,
    output logic       ready,
    output logic       card_valid,
    output logic [5:0] card_idx,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [3:0] card_value,
    output logic [5:0] cards_left
);

    localparam logic [15:0] TAP_MASK  = 16'hB400;
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [5:0]  LAST_CARD = 6'd51;
    localparam logic [5:0]  DECK_SIZE = 6'd52;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_READY   = 2'd2,
        ST_EMPTY   = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) begin
            s = s ^ TAP_MASK;
        end else begin
            s = s;
        end
        return s;
    endfunction

    function automatic logic [1:0] suit_of(input logic [5:0] idx);
        logic [1:0] s;
        if (idx >= 6'd39)      s = 2'd3;
        else if (idx >= 6'd26) s = 2'd2;
        else if (idx >= 6'd13) s = 2'd1;
        else                   s = 2'd0;
        return s;
    endfunction

    // Rank is idx minus the suit base plus one, done as one subtract per suit band.
    function automatic logic [3:0] rank_of(input logic [5:0] idx);
        logic [5:0] r;
        if (idx >= 6'd39)      r = idx - 6'd38;
        else if (idx >= 6'd26) r = idx - 6'd25;
        else if (idx >= 6'd13) r = idx - 6'd12;
        else                   r = idx + 6'd1;
        return r[3:0];
    endfunction

    function automatic logic [3:0] value_of(input logic [3:0] rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

    state_t      state_r, state_next_s;
    logic [5:0]  deck_r [0:51];
    logic [15:0] lfsr_r;
    logic [5:0]  cnt_r, cnt_next_s;
    logic [5:0]  ptr_r, ptr_next_s;
    logic [5:0]  left_r, left_next_s;
    logic        ready_r, valid_r;
    logic [5:0]  card_idx_r;
    logic [3:0]  card_rank_r, card_value_r;
    logic [1:0]  card_suit_r;
    logic        accept_s, swap_s;
    logic [5:0]  j_s, top_card_s;

    assign j_s        = lfsr_r[5:0];
    assign top_card_s = deck_r[ptr_r];

    // Next-state, counter and pointer logic; cnt_r is the fill index in INIT and i in SHUFFLE
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        ptr_next_s   = ptr_r;
        left_next_s  = left_r;
        accept_s     = 1'b0;
        swap_s       = 1'b0;
        case (state_r)
            ST_INIT: begin
                // Always pass through SHUFFLE: it is what loads the full shoe count.
                if (cnt_r == LAST_CARD) begin
                    state_next_s = ST_SHUFFLE;
                    cnt_next_s   = LAST_CARD;
                end else begin
                    cnt_next_s = cnt_r + 6'd1;
                end
            end
            ST_SHUFFLE: begin
                if (!SHUFFLE_EN || cnt_r == 6'd0) begin
                    state_next_s = ST_READY;
                    ptr_next_s   = 6'd0;
                    left_next_s  = DECK_SIZE;
                end else if (j_s <= cnt_r) begin
                    swap_s     = 1'b1;
                    cnt_next_s = cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        state_next_s = ST_READY;
                        ptr_next_s   = 6'd0;
                        left_next_s  = DECK_SIZE;
                    end else begin
                        state_next_s = ST_SHUFFLE;
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            ST_READY: begin
                if (ready_r && draw_req) begin
                    accept_s    = 1'b1;
                    left_next_s = left_r - 6'd1;
                    if (left_r == 6'd1) begin
                        ptr_next_s   = 6'd0;
                        state_next_s = AUTO_RESHUFFLE ? ST_SHUFFLE : ST_EMPTY;
                        cnt_next_s   = LAST_CARD;
                    end else begin
                        ptr_next_s = ptr_r + 6'd1;
                    end
                end else begin
                    accept_s = 1'b0;
                end
                // The draw above is still served; the shuffle starts on the same edge.
                if (shuffle_req) begin
                    state_next_s = ST_SHUFFLE;
                    cnt_next_s   = LAST_CARD;
                end else begin
                    cnt_next_s = cnt_next_s;
                end
            end
            ST_EMPTY: begin
                if (shuffle_req) begin
                    state_next_s = ST_SHUFFLE;
                    cnt_next_s   = LAST_CARD;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            default: begin
                state_next_s = ST_INIT;
                cnt_next_s   = 6'd0;
            end
        endcase
    end

    // Deck storage: identity fill during INIT, one swap per accepted shuffle candidate
    always_ff @(posedge clock) begin
        if (!reset && state_r == ST_INIT) begin
            deck_r[cnt_r] <= cnt_r;
        end else if (!reset && swap_s) begin
            deck_r[cnt_r] <= deck_r[j_s];
            deck_r[j_s]   <= deck_r[cnt_r];
        end
    end

    // Control state, LFSR and registered card outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_INIT;
            lfsr_r       <= SEED_EFF;
            cnt_r        <= 6'd0;
            ptr_r        <= 6'd0;
            left_r       <= 6'd0;
            ready_r      <= 1'b0;
            valid_r      <= 1'b0;
            card_idx_r   <= 6'd0;
            card_rank_r  <= 4'd0;
            card_suit_r  <= 2'd0;
            card_value_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            lfsr_r  <= lfsr_step(lfsr_r);
            cnt_r   <= cnt_next_s;
            ptr_r   <= ptr_next_s;
            left_r  <= left_next_s;
            ready_r <= (state_next_s == ST_READY) && (left_next_s != 6'd0);
            valid_r <= accept_s;
            if (accept_s) begin
                card_idx_r   <= top_card_s;
                card_rank_r  <= rank_of(top_card_s);
                card_suit_r  <= suit_of(top_card_s);
                card_value_r <= value_of(rank_of(top_card_s));
            end
        end
    end

    assign ready      = ready_r;
    assign card_valid = valid_r;
    assign card_idx   = card_idx_r;
    assign card_rank  = card_rank_r;
    assign card_suit  = card_suit_r;
    assign card_value = card_value_r;
    assign cards_left = left_r;

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Scoreboard bench for card_shoe_dealer: three instances (identity/auto, shuffled/auto,
// identity/no-auto), randomized draw/shuffle traffic checked against a counting deck model.
module tb_card_shoe_dealer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] reset_v, draw_v, shuf_v, ready_v, valid_v;
    logic [5:0] idx_v   [3];
    logic [3:0] rank_v  [3];
    logic [1:0] suit_v  [3];
    logic [3:0] value_v [3];
    logic [5:0] left_v  [3];

    card_shoe_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b0), .AUTO_RESHUFFLE(1'b1)) u_id (
        .clock(clock), .reset(reset_v[0]), .draw_req(draw_v[0]), .shuffle_req(shuf_v[0]),
        .ready(ready_v[0]), .card_valid(valid_v[0]), .card_idx(idx_v[0]), .card_rank(rank_v[0]),
        .card_suit(suit_v[0]), .card_value(value_v[0]), .cards_left(left_v[0]));

    card_shoe_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b1), .AUTO_RESHUFFLE(1'b1)) u_sh (
        .clock(clock), .reset(reset_v[1]), .draw_req(draw_v[1]), .shuffle_req(shuf_v[1]),
        .ready(ready_v[1]), .card_valid(valid_v[1]), .card_idx(idx_v[1]), .card_rank(rank_v[1]),
        .card_suit(suit_v[1]), .card_value(value_v[1]), .cards_left(left_v[1]));

    card_shoe_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b0), .AUTO_RESHUFFLE(1'b0)) u_na (
        .clock(clock), .reset(reset_v[2]), .draw_req(draw_v[2]), .shuffle_req(shuf_v[2]),
        .ready(ready_v[2]), .card_valid(valid_v[2]), .card_idx(idx_v[2]), .card_rank(rank_v[2]),
        .card_suit(suit_v[2]), .card_value(value_v[2]), .cards_left(left_v[2]));

    typedef struct {
        int dut;
        int idx;
        int left;
    } exp_t;

    exp_t sb_q[$];
    int   run_q[$];
    int   run1[$];
    int   checks = 0;
    int   failures = 0;
    int   model_left = 52;
    int   val_sum = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented card must match the oldest scoreboard entry
    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (valid_v[d] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_card: dut %0d gave idx %0d, expected no card", d, idx_v[d]);
                end else begin
                    exp_t e;
                    int   ix;
                    int   rk;
                    e  = sb_q.pop_front();
                    ix = int'(idx_v[d]);
                    rk = ix % 13 + 1;
                    check("card_dut", d, e.dut);
                    if (e.idx >= 0) check("card_idx", ix, e.idx);
                    check("cards_left", int'(left_v[d]), e.left);
                    check("card_rank", int'(rank_v[d]), rk);
                    check("card_suit", int'(suit_v[d]), ix / 13);
                    check("card_value", int'(value_v[d]), (rk > 10) ? 10 : rk);
                    if (d == 1) begin
                        run_q.push_back(ix);
                        val_sum += int'(value_v[d]);
                    end
                end
            end
        end
    end

    // Present one cycle of inputs; record the expected card when the draw will be accepted.
    task automatic step(input int d, input bit dr, input bit sr);
        exp_t e;
        draw_v[d] = dr;
        shuf_v[d] = sr;
        if (dr && ready_v[d]) begin
            e.dut  = d;
            e.idx  = (d == 1) ? -1 : 52 - model_left;
            model_left--;
            e.left = model_left;
            sb_q.push_back(e);
        end
        if (model_left == 0 || (sr && ready_v[d])) model_left = 52;
        @(negedge clock);
    endtask

    task automatic wait_ready(input int d, input int budget);
        int n = 0;
        while (!ready_v[d] && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("ready_rise", int'(ready_v[d]), 1);
    endtask

    task automatic check_zero(input int d);
        check("zero_ready", int'(ready_v[d]), 0);
        check("zero_valid", int'(valid_v[d]), 0);
        check("zero_idx", int'(idx_v[d]), 0);
        check("zero_rank", int'(rank_v[d]), 0);
        check("zero_suit", int'(suit_v[d]), 0);
        check("zero_value", int'(value_v[d]), 0);
        check("zero_left", int'(left_v[d]), 0);
    endtask

    // Reset the shuffled instance, poke draws while it is busy, then deal a full shoe.
    task automatic run_shuffle_deal(output int lat);
        reset_v[1] = 1'b1;
        draw_v[1]  = 1'b0;
        shuf_v[1]  = 1'b0;
        repeat (2) @(negedge clock);
        reset_v[1] = 1'b0;
        lat = 0;
        while (!ready_v[1] && lat < 5000) begin
            step(1, (lat % 3) == 0, 1'b0);
            lat++;
        end
        draw_v[1] = 1'b0;
        check("sh_ready_rise", int'(ready_v[1]), 1);
        check("sh_left_full", int'(left_v[1]), 52);
        model_left = 52;
        run_q.delete();
        val_sum = 0;
        repeat (52) step(1, 1'b1, 1'b0);
        check("sh_exhaust_ready", int'(ready_v[1]), 0);
        draw_v[1] = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  lat1, lat2;
        int  distinct, identity, mism;
        bit  evt_last;
        bit  seen [52];

        reset_v = 3'b111;
        draw_v  = 3'b000;
        shuf_v  = 3'b000;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 3; d++) check_zero(d);

        // Identity deck, full deal, auto reshuffle, second deal
        reset_v[0] = 1'b0;
        n = 0;
        while (!ready_v[0] && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("id_ready_latency", n, 53);
        check("id_left_full", int'(left_v[0]), 52);
        model_left = 52;
        repeat (52) step(0, 1'b1, 1'b0);
        check("id_exhaust_ready", int'(ready_v[0]), 0);
        draw_v[0] = 1'b0;
        wait_ready(0, 20);
        check("id_reshuffle_left", int'(left_v[0]), 52);
        repeat (52) step(0, 1'b1, 1'b0);
        draw_v[0] = 1'b0;
        wait_ready(0, 20);

        // Simultaneous draw and shuffle request at 40 cards left
        repeat (12) step(0, 1'b1, 1'b0);
        check("id_left_40", int'(left_v[0]), 40);
        step(0, 1'b1, 1'b1);
        check("combo_ready_low", int'(ready_v[0]), 0);
        draw_v[0] = 1'b0;
        shuf_v[0] = 1'b0;
        wait_ready(0, 20);
        check("combo_left_full", int'(left_v[0]), 52);

        // Random draw/shuffle traffic; ready must dip for exactly one cycle after each reshuffle
        evt_last = 1'b0;
        for (int c = 0; c < 300; c++) begin
            bit dr, sr;
            check("rand_ready", int'(ready_v[0]), evt_last ? 0 : 1);
            dr = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 31) == 0);
            evt_last = ready_v[0] && (sr || (dr && model_left == 1));
            step(0, dr, sr);
        end
        draw_v[0] = 1'b0;
        shuf_v[0] = 1'b0;
        repeat (2) @(negedge clock);

        // Shuffled deck: permutation, value sum, not identity, deterministic replay
        run_shuffle_deal(lat1);
        run1 = run_q;
        foreach (seen[k]) seen[k] = 1'b0;
        distinct = 0;
        identity = 1;
        foreach (run1[k]) begin
            if (run1[k] >= 0 && run1[k] < 52 && !seen[run1[k]]) begin
                seen[run1[k]] = 1'b1;
                distinct++;
            end
            if (run1[k] != k) identity = 0;
        end
        check("sh_card_count", run1.size(), 52);
        check("sh_distinct", distinct, 52);
        check("sh_value_sum", val_sum, 340);
        check("sh_not_identity", identity, 0);

        run_shuffle_deal(lat2);
        check("sh_replay_latency", lat2, lat1);
        check("sh_replay_count", run_q.size(), 52);
        mism = 0;
        foreach (run1[k]) begin
            if (k >= run_q.size() || run_q[k] != run1[k]) mism++;
        end
        check("sh_replay_seq", mism, 0);

        // Reset while reshuffling clears everything and restarts the fill
        check("mid_shuffle_busy", int'(ready_v[1]), 0);
        reset_v[1] = 1'b1;
        @(negedge clock);
        check_zero(1);
        reset_v[1] = 1'b0;
        n = 0;
        while (!ready_v[1] && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("restart_ready", int'(ready_v[1]), 1);
        check("restart_includes_init", (n > 52) ? 1 : 0, 1);
        check("restart_left_full", int'(left_v[1]), 52);

        // No auto reshuffle: EMPTY ignores draws until shuffle_req
        reset_v[2] = 1'b0;
        wait_ready(2, 100);
        model_left = 52;
        repeat (52) step(2, 1'b1, 1'b0);
        repeat (10) begin
            step(2, 1'b1, 1'b0);
            check("empty_ready", int'(ready_v[2]), 0);
            check("empty_left", int'(left_v[2]), 0);
        end
        step(2, 1'b0, 1'b1);
        shuf_v[2] = 1'b0;
        wait_ready(2, 20);
        check("empty_refill_left", int'(left_v[2]), 52);
        model_left = 52;
        repeat (3) step(2, 1'b1, 1'b0);
        draw_v[2] = 1'b0;
        repeat (2) @(negedge clock);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
